// File: rtl/audio_pkg.sv
// Shared types for the PT8211 serial audio receive path.
// Sample/frame typedefs and receiver state encoding.
package audio_pkg;

  localparam int AUDIO_DW = 16;

  typedef logic [AUDIO_DW-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_frame_t;

  typedef enum logic [1:0] {
    HUNT,
    RIGHT,
    LEFT
  } rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous line,
// with single-cycle rise/fall pulses on the synchronised value.
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/pt8211_rx.sv
// PT8211-format (LSB-justified, WS low = right) serial audio receiver
// delivering {left,right} frames on a valid/ready interface.
module pt8211_rx
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 6
) (
  input  logic                  clk_27mhz,
  input  logic                  reset,
  input  logic                  bck,
  input  logic                  ws,
  input  logic                  din,
  output logic [DATA_WIDTH-1:0] out_left,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH:0]   CNT_DW  = (CNT_WIDTH+1)'(DATA_WIDTH);

  logic bck_rise, ws_s, din_s;
  logic unused_bck_q, unused_bck_fall;
  logic unused_ws_rise, unused_ws_fall;
  logic unused_din_rise, unused_din_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_bck (
    .clk_i (clk_27mhz),
    .rst_i (reset),
    .d_i   (bck),
    .q_o   (unused_bck_q),
    .rise_o(bck_rise),
    .fall_o(unused_bck_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_ws (
    .clk_i (clk_27mhz),
    .rst_i (reset),
    .d_i   (ws),
    .q_o   (ws_s),
    .rise_o(unused_ws_rise),
    .fall_o(unused_ws_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_din (
    .clk_i (clk_27mhz),
    .rst_i (reset),
    .d_i   (din),
    .q_o   (din_s),
    .rise_o(unused_din_rise),
    .fall_o(unused_din_fall)
  );

  rx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  wsp_q, wsp_d;
  logic [DATA_WIDTH-1:0] rbuf_q, rbuf_d;
  logic                  rok_q, rok_d;
  logic                  lead_q, lead_d;
  logic [DATA_WIDTH-1:0] left_q, left_d;
  logic [DATA_WIDTH-1:0] right_q, right_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic                  ovr_q, ovr_d;
  logic                  done, accept, cnt_ge;

  assign cnt_ge = {1'b0, cnt_q} >= CNT_DW;
  assign accept = valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    wsp_d   = wsp_q;
    rbuf_d  = rbuf_q;
    rok_d   = rok_q;
    lead_d  = lead_q;
    left_d  = left_q;
    right_d = right_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    ovr_d   = 1'b0;
    done    = 1'b0;

    if (bck_rise) begin
      wsp_d = ws_s;
      if (ws_s != wsp_q) begin
        // ws change: previous word ended last edge, this bit opens a new one
        shift_d = {{(DATA_WIDTH-1){1'b0}}, din_s};
        cnt_d   = CNT_WIDTH'(1);
        unique case (state_q)
          HUNT: begin
            state_d = ws_s ? LEFT : RIGHT;
            rok_d   = 1'b0;
            lead_d  = ws_s;
          end
          RIGHT: begin
            state_d = LEFT;
            lead_d  = 1'b0;
            if (cnt_ge) begin
              rbuf_d = shift_q;
              rok_d  = 1'b1;
            end else begin
              rok_d = 1'b0;
              err_d = 1'b1;
            end
          end
          LEFT: begin
            state_d = RIGHT;
            rok_d   = 1'b0;
            lead_d  = 1'b0;
            if (!lead_q) begin
              if (!cnt_ge)    err_d = 1'b1;
              else if (rok_q) done  = 1'b1;
            end
          end
          default: state_d = HUNT;
        endcase
      end else begin
        shift_d = {shift_q[DATA_WIDTH-2:0], din_s};
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end

    if (accept) valid_d = 1'b0;

    if (done) begin
      if (!valid_q || accept) begin
        left_d  = shift_q;
        right_d = rbuf_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_27mhz) begin
    if (reset) begin
      state_q <= HUNT;
      shift_q <= '0;
      cnt_q   <= '0;
      wsp_q   <= 1'b0;
      rbuf_q  <= '0;
      rok_q   <= 1'b0;
      lead_q  <= 1'b0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      wsp_q   <= wsp_d;
      rbuf_q  <= rbuf_d;
      rok_q   <= rok_d;
      lead_q  <= lead_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
    end
  end

  assign out_left  = left_q;
  assign out_right = right_q;
  assign out_valid = valid_q;
  assign frame_err = err_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_pt8211_rx.sv
// Bench for pt8211_rx: serial stimulus at bck = clk/4,
// frames scored against an expected-frame queue.
module tb_pt8211_rx;
  import audio_pkg::*;

  logic        clk_27mhz = 1'b0;
  logic        reset     = 1'b1;
  logic        bck       = 1'b0;
  logic        ws        = 1'b0;
  logic        din       = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] out_left, out_right;
  logic        out_valid, frame_err, overrun;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_ovr   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 clk_27mhz = ~clk_27mhz;

  pt8211_rx #(
    .DATA_WIDTH (16),
    .SYNC_STAGES(2),
    .CNT_WIDTH  (6)
  ) dut (
    .clk_27mhz(clk_27mhz),
    .reset    (reset),
    .bck      (bck),
    .ws       (ws),
    .din      (din),
    .out_left (out_left),
    .out_right(out_right),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always @(negedge clk_27mhz) begin
    if (frame_err) n_err++;
    if (overrun) n_ovr++;
    if (out_valid && out_ready) begin
      n_valid++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_frame got L=%h R=%h required none",
                 out_left, out_right);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_left, out_right} !== mon_exp) begin
          bad++;
          $display("FAIL frame got L=%h R=%h required L=%h R=%h",
                   out_left, out_right, mon_exp[31:16], mon_exp[15:0]);
        end
      end
    end
  end

  task automatic send_bit(input logic w, input logic d);
    ws  = w;
    din = d;
    #20 bck = 1'b1;
    #20 bck = 1'b0;
  endtask

  task automatic send_word(input logic w, input logic [31:0] data,
                           input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(w, data[i]);
  endtask

  task automatic align_phase();
    int p;
    p = $urandom_range(1, 9);
    @(posedge clk_27mhz);
    #p;
  endtask

  task automatic settle();
    repeat (12) @(posedge clk_27mhz);
    @(negedge clk_27mhz);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(posedge clk_27mhz);
    @(negedge clk_27mhz);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_valid got %b required 0", out_valid);
    end
    total++;
    if (out_left !== 16'h0) begin
      bad++; $display("FAIL rst_left got %h required 0000", out_left);
    end
    total++;
    if (out_right !== 16'h0) begin
      bad++; $display("FAIL rst_right got %h required 0000", out_right);
    end
    total++;
    if (frame_err !== 1'b0) begin
      bad++; $display("FAIL rst_err got %b required 0", frame_err);
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++; $display("FAIL rst_ovr got %b required 0", overrun);
    end
    total++;
    if (dut.state_q !== HUNT) begin
      bad++; $display("FAIL rst_state got %0d required HUNT", dut.state_q);
    end
    @(posedge clk_27mhz);
    #1 reset = 1'b0;
    repeat (5) @(posedge clk_27mhz);
    @(negedge clk_27mhz);
    total++;
    if ((n_err + n_ovr + n_valid) !== 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_pulses got err=%0d ovr=%0d vld=%0d required 0",
               n_err, n_ovr, n_valid);
    end
  endtask

  task automatic test_basic();
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    align_phase();
    send_word(1'b1, 32'h15, 5);
    exp_q.push_back({16'hABCD, 16'h1234});
    send_word(1'b0, 32'h1234, 16);
    send_word(1'b1, 32'hABCD, 16);
    send_bit(1'b0, 1'b0);
    settle();
    total++;
    if (n_valid - v0 !== 1) begin
      bad++; $display("FAIL basic_count got %0d required 1", n_valid - v0);
    end
    total++;
    if (n_err - e0 !== 0) begin
      bad++; $display("FAIL basic_err got %0d required 0", n_err - e0);
    end
  endtask

  task automatic test_wide();
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    align_phase();
    exp_q.push_back({16'h7FFE, 16'h8001});
    send_word(1'b0, 32'h0000_8001, 32);
    send_word(1'b1, 32'hFFFF_7FFE, 32);
    send_bit(1'b0, 1'b0);
    settle();
    total++;
    if (n_valid - v0 !== 1) begin
      bad++; $display("FAIL wide_count got %0d required 1", n_valid - v0);
    end
    total++;
    if (n_err - e0 !== 0) begin
      bad++; $display("FAIL wide_err got %0d required 0", n_err - e0);
    end
  endtask

  task automatic test_short();
    int v0, e0;
    v0 = n_valid;
    e0 = n_err;
    align_phase();
    send_word(1'b0, 32'hA5, 8);
    send_word(1'b1, 32'h5555, 16);
    send_bit(1'b0, 1'b0);
    settle();
    total++;
    if (n_err - e0 !== 1) begin
      bad++; $display("FAIL short_err got %0d required 1", n_err - e0);
    end
    total++;
    if (n_valid - v0 !== 0) begin
      bad++; $display("FAIL short_count got %0d required 0", n_valid - v0);
    end
  endtask

  task automatic test_overrun();
    int v0, o0;
    v0 = n_valid;
    o0 = n_ovr;
    @(posedge clk_27mhz);
    #1 out_ready = 1'b0;
    align_phase();
    exp_q.push_back({16'h2222, 16'h1111});
    send_word(1'b0, 32'h1111, 16);
    send_word(1'b1, 32'h2222, 16);
    send_word(1'b0, 32'h3333, 16);
    send_word(1'b1, 32'h4444, 16);
    send_bit(1'b0, 1'b0);
    settle();
    total++;
    if (n_ovr - o0 !== 1) begin
      bad++; $display("FAIL ovr_pulse got %0d required 1", n_ovr - o0);
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL ovr_valid got %b required 1", out_valid);
    end
    total++;
    if (out_left !== 16'h2222) begin
      bad++; $display("FAIL ovr_left got %h required 2222", out_left);
    end
    total++;
    if (out_right !== 16'h1111) begin
      bad++; $display("FAIL ovr_right got %h required 1111", out_right);
    end
    total++;
    if (n_valid - v0 !== 0) begin
      bad++; $display("FAIL ovr_early got %0d required 0", n_valid - v0);
    end
    @(posedge clk_27mhz);
    #1 out_ready = 1'b1;
    repeat (3) @(posedge clk_27mhz);
    @(negedge clk_27mhz);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL ovr_drop got %b required 0", out_valid);
    end
    total++;
    if (n_valid - v0 !== 1) begin
      bad++; $display("FAIL ovr_count got %0d required 1", n_valid - v0);
    end
  endtask

  task automatic test_reset_mid();
    int v0, e0;
    align_phase();
    send_word(1'b0, 32'h0F0F, 16);
    send_word(1'b1, 32'h3C, 8);
    @(posedge clk_27mhz);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk_27mhz);
    #1 reset = 1'b0;
    @(negedge clk_27mhz);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_rst_valid got %b required 0", out_valid);
    end
    v0 = n_valid;
    e0 = n_err;
    align_phase();
    exp_q.push_back({16'hDDDD, 16'hCCCC});
    send_word(1'b0, 32'hAAAA, 16);
    send_word(1'b1, 32'hBBBB, 16);
    send_word(1'b0, 32'hCCCC, 16);
    send_word(1'b1, 32'hDDDD, 16);
    send_bit(1'b0, 1'b0);
    settle();
    total++;
    if (n_valid - v0 !== 1) begin
      bad++; $display("FAIL mid_count got %0d required 1", n_valid - v0);
    end
    total++;
    if (n_err - e0 !== 0) begin
      bad++; $display("FAIL mid_err got %0d required 0", n_err - e0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wide();
    test_short();
    test_overrun();
    test_reset_mid();
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL pending_frames got %0d required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
